// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RISC-V pipeline.
// `HAZARD_FWD_EN selects EX-operand forwarding; without it every RAW on E/M stalls D.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic                 UseRs1D,
  input  logic                 UseRs2D,
  input  logic [4:0]           RdD,
  input  logic                 RegWriteD,
  input  logic                 ResultSrcD,
  input  logic                 PCSrcE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic [CNT_WIDTH-1:0] StallCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } slot_t;

  slot_t e_q, e_d;
  slot_t m_q, m_d;
  slot_t w_q, w_d;

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic       stall_hit;
  logic       hold;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       unused_w;

  function automatic logic is_writer(input slot_t s);
    return s.valid && s.regwrite && (s.rd != 5'd0);
  endfunction

  function automatic logic src_match(input logic use_rs, input logic [4:0] rs, input slot_t s);
    return use_rs && (rs != 5'd0) && (rs == s.rd) && is_writer(s);
  endfunction

`ifdef HAZARD_FWD_EN
  // M is checked first so the newest in-flight value wins over W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input slot_t m, input slot_t w);
    if (rs == 5'd0)                          return 2'b00;
    else if (rs == m.rd && is_writer(m))     return 2'b10;
    else if (rs == w.rd && is_writer(w))     return 2'b01;
    else                                     return 2'b00;
  endfunction
`endif

  always_comb begin
    stall_hit = 1'b0;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
`ifdef HAZARD_FWD_EN
    stall_hit = e_q.load &&
                (src_match(UseRs1D, Rs1D, e_q) || src_match(UseRs2D, Rs2D, e_q));
    fwd_a     = fwd_sel(e_q.rs1, m_q, w_q);
    fwd_b     = fwd_sel(e_q.rs2, m_q, w_q);
`else
    // W needs no check: the register file is write-first.
    stall_hit = src_match(UseRs1D, Rs1D, e_q) || src_match(UseRs2D, Rs2D, e_q) ||
                src_match(UseRs1D, Rs1D, m_q) || src_match(UseRs2D, Rs2D, m_q);
`endif
  end

  always_comb begin
    hold      = stall_hit && !PCSrcE;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      StallF    = hold;
      StallD    = hold;
      FlushD    = PCSrcE;
      FlushE    = PCSrcE || hold;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
    end
  end

  always_comb begin
    if (FlushE) begin
      e_d = '0;
    end else begin
      e_d.valid    = 1'b1;
      e_d.rd       = RdD;
      e_d.regwrite = RegWriteD;
      e_d.load     = ResultSrcD;
      e_d.rs1      = Rs1D;
      e_d.rs2      = Rs2D;
    end
    m_d         = e_q;
    w_d         = m_q;
    stall_cnt_d = stall_cnt_q + (StallD ? CNT_WIDTH'(1) : '0);
    flush_cnt_d = flush_cnt_q + (PCSrcE ? CNT_WIDTH'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    StallCnt = stall_cnt_q;
    FlushCnt = flush_cnt_q;
    unused_w = ^w_q;
  end

endmodule
